// File: rtl/s444_responder.sv
// s444_responder
//   Environment-side partner of the s444 controller. It samples the six s444
//   outputs, decodes a phase code, measures pattern dwell time and drives
//   G0/G1/G2 through a request/acknowledge FSM. Any change of the sampled
//   pattern acknowledges an outstanding request. Stalls set a sticky ERR.
//
// Ports
//   CK                      clock, rising edge
//   RST                     synchronous active-high reset
//   G107..G168              s444 outputs, O = {G168,G167,G119,G118,G108,G107}
//   G0 / G1 / G2            run enable / post-ack hold strobe / request
//   PHASE[2:0]              registered lowest-set-bit index of O (1..6, 0 if none)
//   DWELL[CNT_W-1:0]        cycles since last change of O, saturating
//   CHG                     one-cycle pulse on a change of O
//   ERR                     sticky stall flag
//   SIG[15:0]               MISR signature of O
//
// Build option
//   S444_RESP_SIG_EN        defined: 16-bit MISR (poly 16'h1021) over O
//                           undefined: SIG tied to zero
module s444_responder #(
  parameter int CNT_W     = 4,
  parameter int DWELL_MAX = 15,
  parameter int REQ_DLY   = 3,
  parameter int HOLD_CYC  = 2
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             G107,
  input  logic             G108,
  input  logic             G118,
  input  logic             G119,
  input  logic             G167,
  input  logic             G168,
  output logic             G0,
  output logic             G1,
  output logic             G2,
  output logic [2:0]       PHASE,
  output logic [CNT_W-1:0] DWELL,
  output logic             CHG,
  output logic             ERR,
  output logic [15:0]      SIG
);

  localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] DMAX    = CNT_W'(DWELL_MAX);
  localparam logic [CNT_W-1:0] REQ_THR = CNT_W'(REQ_DLY);
  localparam logic [HC_W-1:0]  HOLD_LD = HC_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_REQ,
    S_HOLD
  } state_t;

  logic [5:0]       w_o;
  logic             w_diff;
  logic [2:0]       w_phase;
  logic [5:0]       r_oq;
  logic [CNT_W-1:0] r_dwell;
  logic             r_chg;
  logic [2:0]       r_phase;
  logic             r_err;
  logic             r_g0, r_g1, r_g2;
  logic [HC_W-1:0]  r_hold;
  state_t           r_state;

  state_t           w_state_nxt;
  logic [HC_W-1:0]  w_hold_nxt;
  logic             w_err_set;

  assign w_o    = {G168, G167, G119, G118, G108, G107};
  assign w_diff = (w_o != r_oq);

  // Scan from the top bit down so the lowest set bit writes last and wins.
  always_comb begin
    w_phase = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (w_o[5-i]) w_phase = 3'(6 - i);
    end
  end

  // Sampler
  always_ff @(posedge CK) begin
    if (RST) begin
      r_oq    <= '0;
      r_chg   <= 1'b0;
      r_dwell <= '0;
      r_phase <= '0;
    end else begin
      r_oq    <= w_o;
      r_chg   <= w_diff;
      r_phase <= w_phase;
      if (w_diff)
        r_dwell <= '0;
      else if (r_dwell != DMAX)
        r_dwell <= r_dwell + 1'b1;
    end
  end

  // FSM next-state; CHG is tested before saturation so an acknowledge
  // always beats a stall report.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_ARM;
      S_ARM:  if (r_dwell >= REQ_THR) w_state_nxt = S_REQ;
      S_REQ: begin
        if (r_chg) begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = HOLD_LD;
        end else if (r_dwell == DMAX) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_ARM;
        end
      end
      S_HOLD: begin
        if (r_hold == '0) w_state_nxt = S_ARM;
        else              w_hold_nxt  = r_hold - 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; G0..G2 are registered from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_err   <= 1'b0;
      r_g0    <= 1'b0;
      r_g1    <= 1'b0;
      r_g2    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_err   <= r_err | w_err_set;
      r_g0    <= (w_state_nxt != S_IDLE);
      r_g1    <= (w_state_nxt == S_HOLD);
      r_g2    <= (w_state_nxt == S_REQ);
    end
  end

`ifdef S444_RESP_SIG_EN
  logic [15:0] r_sig;
  always_ff @(posedge CK) begin
    if (RST)
      r_sig <= '0;
    else
      r_sig <= {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000)
               ^ {10'b0, w_o};
  end
  assign SIG = r_sig;
`else
  assign SIG = '0;
`endif

  assign G0    = r_g0;
  assign G1    = r_g1;
  assign G2    = r_g2;
  assign PHASE = r_phase;
  assign DWELL = r_dwell;
  assign CHG   = r_chg;
  assign ERR   = r_err;

endmodule

// File: doc/s444_responder.md
# s444_responder

Environment-side counterpart of the s444 sequential controller. It samples the six s444 outputs (G107, G108, G118, G119, G167, G168), decodes them into a phase code, and measures how long each output pattern lasts. It drives the three s444 inputs (G0, G1, G2) through a request/acknowledge state machine, in which any change of the s444 output pattern acknowledges a request. It sits beside s444 in the closed-loop benchmark harness and flags stalls with a sticky error.

## Interface
- CNT_W, 4: width of the dwell counter.
- DWELL_MAX, 15: dwell saturation value and stall threshold; must be ≤ 2^CNT_W−1.
- REQ_DLY, 3: dwell count that must be reached in ARM before a request is raised; must be < DWELL_MAX.
- HOLD_CYC, 2: number of cycles G1 stays high after an acknowledge; must be ≥ 1.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- G107, G108, G118, G119, G167, G168  in  1 each  s444 outputs; O = {G168,G167,G119,G118,G108,G107}.
- G0  out  1  run enable to s444.
- G1  out  1  post-acknowledge hold strobe to s444.
- G2  out  1  request to s444.
- PHASE  out  3  registered priority decode of O.
- DWELL  out  CNT_W  cycles since the last change of O, saturating.
- CHG  out  1  one-cycle pulse marking a change of O.
- ERR  out  1  sticky stall flag.
- SIG  out  16  signature of O; see Configuration.

## Operation
- Reset values (all outputs and state): O_q=0, CHG=0, DWELL=0, PHASE=0, ERR=0, SIG=0, G0=G1=G2=0, hold counter=0, state IDLE. RST has priority over every other update at the same edge.
- Sampler, updated every edge:
  - O_q ← O.
  - CHG ← (O ≠ O_q).
  - If O ≠ O_q then DWELL ← 0; otherwise DWELL ← min(DWELL+1, DWELL_MAX).
- PHASE ← index of the lowest set bit of O, counting from 1 (G107=1 … G168=6); PHASE ← 0 if O=0.
- FSM (Moore; the state register and G0/G1/G2 are updated at the same edge):
  - IDLE: G0=0, G1=0, G2=0. Always moves to ARM on the next edge.
  - ARM: G0=1. Moves to REQ when DWELL ≥ REQ_DLY.
  - REQ: G0=1, G2=1.
    - If CHG=1: move to HOLD and load the hold counter with HOLD_CYC−1.
    - Else if DWELL == DWELL_MAX: set ERR and move to ARM.
  - HOLD: G0=1, G1=1. Decrements the hold counter each edge; moves to ARM when the counter is 0.
- Simultaneous events:
  - CHG and saturated DWELL cannot coincide, because a change clears DWELL at the same edge. If both are presented, CHG wins and ERR is not set.
  - Changes of O during ARM or HOLD update DWELL, CHG and PHASE but do not alter the FSM path.
- ERR is cleared only by RST.
- Reset mid-operation: RST asserted in any state returns the block to IDLE with all outputs at reset values at the next edge.

## Timing
- O to CHG, DWELL and PHASE: 1 cycle.
- O change to REQ→HOLD transition: 2 cycles (sample edge, then FSM edge). G2 falls and G1 rises on the same edge.
- After reset release: G0=1 at edge 1. With defaults and O held at 0, G2=1 from edge 4.
- Stall with defaults: DWELL saturates at 15 at edge 15; ERR=1 and state ARM at edge 16; REQ is re-entered at edge 17.
- G1 is high for exactly HOLD_CYC cycles per acknowledge.

## Configuration
- S444_RESP_SIG_EN defined: a 16-bit MISR runs every cycle, with fb = SIG[15]:
  - SIG ← (SIG<<1) ^ (fb ? 16'h1021 : 0) ^ {10'b0, O}.
  - Reset value is 0.
- S444_RESP_SIG_EN undefined: no MISR logic is built and SIG is tied to 16'h0000.

## Test plan
- Reset: RST=1 for 2 cycles with O=0 → every output is 0. Release → G0=1 at edge 1, DWELL=3 at edge 3, G2=1 at edge 4.
- Acknowledge: in REQ, set O=6'b000001 → next edge CHG=1, DWELL=0, PHASE=1 → following edge G2=0, G1=1 for 2 cycles → then ARM with G1=0.
- Stall: hold O=0 after reset → ERR=1 at edge 16 and stays 1 through later REQ cycles, until RST.
- Priority decode: O=6'b101100 → PHASE=3; O=6'b100000 → PHASE=6; O=0 → PHASE=0.
- Mid-operation reset: assert RST while in HOLD with G1=1 → next edge G0=G1=G2=0, ERR=0, DWELL=0, state IDLE.
- Signature, with S444_RESP_SIG_EN: from reset, O=6'b000001 for one cycle, then 0 → SIG=16'h0001, then 16'h0002. Without the macro → SIG stays 16'h0000.
